// File: rtl/dma_pkg.sv
// Shared types and constants for the word-copy DMA engine.
package dma_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/dma_copy.sv
// Single-channel memory-to-memory word copy engine: one READ and one WRITE cycle per word.
// Outputs are registered from the next-state values, so they track the state with no extra latency.
module dma_copy
    import dma_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] remaining,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
);

    localparam logic [31:0] STEP       = 32'(WORD_BYTES);
    localparam logic [31:0] ALIGN_MASK = ~(STEP - 32'd1);

    dma_state_e       state_q, state_d;
    logic [31:0]      src_ptr, src_d;
    logic [31:0]      dst_ptr, dst_d;
    logic [31:0]      data_reg, data_d;
    logic [LEN_W-1:0] rem_d;
    logic             busy_d, done_d, mem_we_d;
    logic [31:0]      mem_a_d, mem_wd_d;

    // Next-state, datapath updates and next-cycle memory port values
    always_comb begin
        state_d = state_q;
        src_d   = src_ptr;
        dst_d   = dst_ptr;
        data_d  = data_reg;
        rem_d   = remaining;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != LEN_W'(0)) begin
                        src_d   = src & ALIGN_MASK;
                        dst_d   = dst & ALIGN_MASK;
                        rem_d   = len;
                        state_d = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                data_d  = mem_rd;
                state_d = WRITE;
            end
            WRITE: begin
                src_d   = src_ptr + STEP;
                dst_d   = dst_ptr + STEP;
                rem_d   = remaining - LEN_W'(1);
                state_d = (remaining == LEN_W'(1)) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        mem_we_d = (state_d == WRITE);
        mem_a_d  = 32'd0;
        mem_wd_d = 32'd0;
        if (state_d == READ) begin
            mem_a_d = src_d;
        end else if (state_d == WRITE) begin
            mem_a_d  = dst_d;
            mem_wd_d = data_d;
        end
    end

    // Async reset clears every register, which also drops mem_we immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            src_ptr   <= 32'd0;
            dst_ptr   <= 32'd0;
            data_reg  <= 32'd0;
            remaining <= LEN_W'(0);
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_a     <= 32'd0;
            mem_wd    <= 32'd0;
        end else begin
            state_q   <= state_d;
            src_ptr   <= src_d;
            dst_ptr   <= dst_d;
            data_reg  <= data_d;
            remaining <= rem_d;
            busy      <= busy_d;
            done      <= done_d;
            mem_we    <= mem_we_d;
            mem_a     <= mem_a_d;
            mem_wd    <= mem_wd_d;
        end
    end

endmodule

// File: tb/tb_dma_copy.sv
// Bench for dma_copy: word-addressed data memory, LED register at 0xC000_0004,
// and a sequential copy model compared against memory contents, latency and bus traffic.
module tb_dma_copy;

    localparam int unsigned LEN_W = 8;
    localparam int unsigned MEM_WORDS = 1024;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src, dst;
    logic [LEN_W-1:0] len;
    logic             busy, done, mem_we;
    logic [LEN_W-1:0] remaining;
    logic [31:0]      mem_a, mem_wd, mem_rd;
    logic [9:0]       leds;

    logic [31:0] dmem [MEM_WORDS];
    logic [31:0] rmem [MEM_WORDS];

    int n_tests = 0;
    int n_fail  = 0;

    int wr_cnt   = 0;
    int done_cnt = 0;
    int idle_bad = 0;
    logic [31:0] rd_log [$];

    dma_copy #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    function automatic int unsigned widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    assign mem_rd = dmem[mem_a[11:2]];

    // Data memory, LED register and bus traffic log
    always @(posedge clk) begin
        if (mem_we) begin
            dmem[mem_a[11:2]] <= mem_wd;
            wr_cnt <= wr_cnt + 1;
            if (mem_a == 32'hC000_0004) leds <= mem_wd[9:0];
        end
        if (busy && !mem_we && !done) rd_log.push_back(mem_a);
        if (done) done_cnt <= done_cnt + 1;
    end

    // The bus must be quiet whenever no word is in flight
    always @(negedge clk) begin
        if (!reset && (!busy || done) && (mem_we || mem_a != 32'd0 || mem_wd != 32'd0))
            idle_bad <= idle_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mem_diff();
        int d = 0;
        for (int i = 0; i < int'(MEM_WORDS); i++)
            if (dmem[i] !== rmem[i]) d++;
        return d;
    endfunction

    task automatic preset(input logic [31:0] a, input logic [31:0] v);
        dmem[widx(a)] = v;
        rmem[widx(a)] = v;
    endtask

    // One copy: model, drive, check latency / busy / remaining / traffic / memory
    task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int n, input int bump);
        logic [31:0] sa, da;
        logic [31:0] exp_rd [$];
        int exp_lat, k, wr0, dn0, rd0, busy_bad, rem_bad, rd_bad;
        bit seen;
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(sa + 32'(4 * i));
            rmem[widx(da + 32'(4 * i))] = rmem[widx(sa + 32'(4 * i))];
        end
        exp_lat  = (n == 0) ? 1 : 2 * n + 1;
        wr0      = wr_cnt;
        dn0      = done_cnt;
        rd0      = rd_log.size();
        busy_bad = 0;
        rem_bad  = 0;
        seen     = 0;

        start = 1'b1; src = s; dst = d; len = LEN_W'(n);
        @(posedge clk); #1;
        k = 1;
        while (k <= exp_lat + 4) begin
            start = (k == bump);
            src   = $urandom;
            dst   = $urandom;
            len   = LEN_W'($urandom);
            if (busy !== 1'b1) busy_bad++;
            if (n > 0 && remaining !== LEN_W'(n - (k - 1) / 2)) rem_bad++;
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
        else check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
        if (n > 0) check({tag, "_remaining"}, 32'(rem_bad), 32'd0);

        @(posedge clk); #1;
        check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulses"}, 32'(done_cnt - dn0), 32'd1);
        check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(n));
        rd_bad = (rd_log.size() - rd0 != n) ? 1 : 0;
        for (int i = 0; i < n && rd_bad == 0; i++)
            if (rd_log[rd0 + i] !== exp_rd[i]) rd_bad = 1;
        check({tag, "_read_addrs"}, 32'(rd_bad), 32'd0);
        check({tag, "_memory"}, 32'(mem_diff()), 32'd0);
    endtask

    initial begin
        logic [31:0] s, d;
        int n;
        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; leds = '0;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            dmem[i] = $urandom;
            rmem[i] = dmem[i];
        end
        #1;
        check("reset_outputs", {busy, done, mem_we, remaining}, 32'd0);
        check("reset_bus", mem_a | mem_wd, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        preset(32'h0, 32'd11); preset(32'h4, 32'd22);
        preset(32'h8, 32'd33); preset(32'hC, 32'd44);
        run_copy("basic", 32'h0, 32'h40, 4, 0);
        check("basic_word3", dmem[19], 32'd44);

        run_copy("zero_len", 32'h100, 32'h200, 0, 0);
        run_copy("start_busy", 32'h80, 32'h300, 3, 2);
        run_copy("wrap", 32'hFFFF_FFFF, 32'h180, 2, 0);

        preset(32'h120, 32'h155);
        run_copy("led", 32'h120, 32'hC000_0004, 1, 0);
        check("led_value", 32'(leds), 32'h155);

        // Reset while writing word 2 of 4: only word 1 lands
        rmem[widx(32'h240)] = rmem[widx(32'h20)];
        start = 1'b1; src = 32'h20; dst = 32'h240; len = LEN_W'(4);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_write", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async", {busy, done, mem_we, remaining}, 32'd0);
        check("rst_bus", mem_a | mem_wd, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_memory", 32'(mem_diff()), 32'd0);
        run_copy("after_rst", 32'h20, 32'h240, 4, 0);

        for (int t = 0; t < 12; t++) begin
            s = $urandom & 32'h1FF;
            d = $urandom & 32'h1FF;
            n = $urandom_range(0, 6);
            run_copy($sformatf("rand%0d", t), s, d, n, (n > 0) ? $urandom_range(1, 2 * n) : 0);
        end

        check("bus_quiet", 32'(idle_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
